// File: rtl/cpu.sv
// Hack CPU: A/D/PC registers around a Hack ALU, one instruction per clk; CPU_HALT_EN adds a halt input.
// Latency: single cycle, outM/writeM combinational from the current instruction; registers update on the edge.
// Backpressure: none by default; with CPU_HALT_EN, halt freezes A, D and PC and suppresses writeM.

module alu (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] x_z, x_n, y_z, y_n, fo;

   always_comb begin
      x_z = zx ? 16'h0000 : x;
      x_n = nx ? ~x_z : x_z;
      y_z = zy ? 16'h0000 : y;
      y_n = ny ? ~y_z : y_z;
      fo  = f ? (x_n + y_n) : (x_n & y_n);
      out = no ? ~fo : fo;
      zr  = (out == 16'h0000);
      ng  = out[15];
   end
endmodule

module cpu (
   input  logic        clk,
   input  logic        reset,
`ifdef CPU_HALT_EN
   input  logic        halt,
`endif
   input  logic [15:0] inM,
   input  logic [15:0] instruction,
   output logic [15:0] outM,
   output logic        writeM,
   output logic [14:0] addressM,
   output logic [14:0] pc
);
   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic [14:0] pc_reg;
   logic [15:0] alu_y;
   logic [15:0] alu_out;
   logic        zr;
   logic        ng;
   logic        is_c;
   logic        jump;
   logic        hold;
   logic        unused_bits;

`ifdef CPU_HALT_EN
   assign hold = halt;
`else
   assign hold = 1'b0;
`endif

   // instruction[14:13] carry no meaning in the Hack encoding
   assign unused_bits = &{1'b0, instruction[14:13]};

   assign is_c  = instruction[15];
   assign alu_y = instruction[12] ? inM : a_reg;

   alu u_alu (
      .x   (d_reg),
      .y   (alu_y),
      .zx  (instruction[11]),
      .nx  (instruction[10]),
      .zy  (instruction[9]),
      .ny  (instruction[8]),
      .f   (instruction[7]),
      .no  (instruction[6]),
      .out (alu_out),
      .zr  (zr),
      .ng  (ng)
   );

   assign jump = is_c & ((instruction[2] & ng) |
                         (instruction[1] & zr) |
                         (instruction[0] & ~ng & ~zr));

   assign outM     = alu_out;
   assign writeM   = is_c & instruction[3] & ~reset & ~hold;
   assign addressM = a_reg[14:0];
   assign pc       = pc_reg;

   // Jump target uses the pre-edge A, so an A write in the same cycle cannot redirect it.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg  <= 16'h0000;
         d_reg  <= 16'h0000;
         pc_reg <= 15'h0000;
      end else if (!hold) begin
         if (!is_c) begin
            a_reg <= instruction;
         end else begin
            if (instruction[5]) a_reg <= alu_out;
            if (instruction[4]) d_reg <= alu_out;
         end
         pc_reg <= jump ? a_reg[14:0] : pc_reg + 15'd1;
      end
   end
endmodule

// File: tb/tb_cpu.sv
// Directed-vector bench for the Hack cpu; covers the halt feature when CPU_HALT_EN is defined.
`timescale 1ns/1ps

module tb_cpu;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] inM;
   logic [15:0] instruction;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM;
   logic [14:0] pc;
`ifdef CPU_HALT_EN
   logic        halt;
`endif

   int total = 0;
   int bad   = 0;

   cpu dut (
      .clk         (clk),
      .reset       (reset),
`ifdef CPU_HALT_EN
      .halt        (halt),
`endif
      .inM         (inM),
      .instruction (instruction),
      .outM        (outM),
      .writeM      (writeM),
      .addressM    (addressM),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      instruction = 16'h0000;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; inM = 16'h0000; instruction = 16'hE7CF;
      #1;
      total++; if (writeM !== 1'b0) begin bad++; $display("FAIL reset_writeM got=%b exp=0", writeM); end
      tick();
      total++; if (pc !== 15'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
      total++; if (addressM !== 15'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addressM); end
      reset = 1'b0; instruction = 16'h0005;
      #1;
      total++; if (writeM !== 1'b0) begin bad++; $display("FAIL ainst_writeM got=%b exp=0", writeM); end
      tick();
      total++; if (addressM !== 15'd5) begin bad++; $display("FAIL first_addr got=%h exp=5", addressM); end
      total++; if (pc !== 15'd1) begin bad++; $display("FAIL first_pc got=%h exp=1", pc); end
   endtask

   task automatic test_alu_store;
      do_reset();
      instruction = 16'h0007; tick();
      instruction = 16'hEC10; tick();
      instruction = 16'hE7C8;
      #1;
      total++; if (outM !== 16'd8) begin bad++; $display("FAIL store_outM got=%h exp=8", outM); end
      total++; if (writeM !== 1'b1) begin bad++; $display("FAIL store_writeM got=%b exp=1", writeM); end
      total++; if (addressM !== 15'd7) begin bad++; $display("FAIL store_addr got=%h exp=7", addressM); end
      tick();
      total++; if (pc !== 15'd3) begin bad++; $display("FAIL store_pc got=%h exp=3", pc); end
      instruction = 16'hE308;
      #1;
      total++; if (outM !== 16'd7) begin bad++; $display("FAIL store_D got=%h exp=7", outM); end
   endtask

   task automatic test_alu_ops;
      logic [15:0] op_instr [6];
      logic [15:0] op_exp   [6];
      op_instr = '{16'hE008, 16'hE548, 16'hE4C8, 16'hE1C8, 16'hF088, 16'hE348};
      op_exp   = '{16'h000F, 16'h0FFF, 16'h0E10, 16'hF1F0, 16'h2143, 16'hF0F0};
      do_reset();
      inM = 16'h1234;
      instruction = 16'h0F0F; tick();
      instruction = 16'hEC10; tick();
      instruction = 16'h00FF; tick();
      for (int i = 0; i < 6; i++) begin
         instruction = op_instr[i];
         #1;
         total++;
         if (outM !== op_exp[i]) begin
            bad++;
            $display("FAIL alu_op%0d instr=%h got=%h exp=%h", i, op_instr[i], outM, op_exp[i]);
         end
      end
      inM = 16'h0000;
   endtask

   task automatic test_jump;
      do_reset();
      instruction = 16'h0064; tick();
      instruction = 16'hEA87; tick();
      total++; if (pc !== 15'd100) begin bad++; $display("FAIL jmp_pc got=%h exp=0064", pc); end
      do_reset();
      instruction = 16'h0064; tick();
      instruction = 16'hE304; tick();
      total++; if (pc !== 15'd2) begin bad++; $display("FAIL jlt_zero got=%h exp=2", pc); end
      instruction = 16'hEE90; tick();
      instruction = 16'hE301; tick();
      total++; if (pc !== 15'd4) begin bad++; $display("FAIL jgt_neg got=%h exp=4", pc); end
      instruction = 16'hE304; tick();
      total++; if (pc !== 15'd100) begin bad++; $display("FAIL jlt_neg got=%h exp=0064", pc); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      instruction = 16'h0014; tick();
      instruction = 16'hE328;
      #1;
      total++; if (addressM !== 15'h0014) begin bad++; $display("FAIL am_addr got=%h exp=0014", addressM); end
      total++; if (writeM !== 1'b1) begin bad++; $display("FAIL am_writeM got=%b exp=1", writeM); end
      tick();
      total++; if (addressM !== 15'd0) begin bad++; $display("FAIL am_newA got=%h exp=0", addressM); end
      instruction = 16'h0014; tick();
      instruction = 16'hEDE7; tick();
      total++; if (pc !== 15'h0014) begin bad++; $display("FAIL ajmp_pc got=%h exp=0014", pc); end
      total++; if (addressM !== 15'h0015) begin bad++; $display("FAIL ajmp_A got=%h exp=0015", addressM); end
   endtask

   task automatic test_wrap;
      do_reset();
      instruction = 16'h7FFF; tick();
      instruction = 16'hEA87; tick();
      total++; if (pc !== 15'h7FFF) begin bad++; $display("FAIL wrap_top got=%h exp=7fff", pc); end
      instruction = 16'h0001; tick();
      total++; if (pc !== 15'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0", pc); end
      total++; if (addressM !== 15'd1) begin bad++; $display("FAIL wrap_addr got=%h exp=1", addressM); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      instruction = 16'hEE90; tick();
      instruction = 16'h0030; tick();
      reset = 1'b1; instruction = 16'hE7CF;
      #1;
      total++; if (writeM !== 1'b0) begin bad++; $display("FAIL mid_writeM got=%b exp=0", writeM); end
      tick();
      total++; if (pc !== 15'd0) begin bad++; $display("FAIL mid_pc got=%h exp=0", pc); end
      total++; if (addressM !== 15'd0) begin bad++; $display("FAIL mid_addr got=%h exp=0", addressM); end
      reset = 1'b0; instruction = 16'hE308;
      #1;
      total++; if (outM !== 16'd0) begin bad++; $display("FAIL mid_D got=%h exp=0", outM); end
   endtask

`ifdef CPU_HALT_EN
   task automatic test_halt;
      do_reset();
      instruction = 16'h0007; tick();
      instruction = 16'hEC10; tick();
      instruction = 16'hE7C8; halt = 1'b1;
      #1;
      total++; if (writeM !== 1'b0) begin bad++; $display("FAIL halt_writeM got=%b exp=0", writeM); end
      for (int i = 0; i < 3; i++) tick();
      total++; if (pc !== 15'd2) begin bad++; $display("FAIL halt_pc got=%h exp=2", pc); end
      total++; if (addressM !== 15'd7) begin bad++; $display("FAIL halt_A got=%h exp=7", addressM); end
      total++; if (outM !== 16'd8) begin bad++; $display("FAIL halt_D got=%h exp=8", outM); end
      halt = 1'b0;
      #1;
      total++; if (writeM !== 1'b1) begin bad++; $display("FAIL resume_writeM got=%b exp=1", writeM); end
      tick();
      total++; if (pc !== 15'd3) begin bad++; $display("FAIL resume_pc got=%h exp=3", pc); end
      halt = 1'b1; reset = 1'b1; tick();
      total++; if (pc !== 15'd0) begin bad++; $display("FAIL halt_reset_pc got=%h exp=0", pc); end
      halt = 1'b0; reset = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      inM = 16'h0000;
      instruction = 16'h0000;
`ifdef CPU_HALT_EN
      halt = 1'b0;
`endif
      #1;
      test_reset();
      test_alu_store();
      test_alu_ops();
      test_jump();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
`ifdef CPU_HALT_EN
      test_halt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameters: none; all widths are fixed by the Hack instruction set.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inM  input  16  data word read from memory at addressM.
REQ-005 instruction  input  16  current instruction fetched from ROM at pc.
REQ-006 outM  output  16  ALU result, valid for memory write.
REQ-007 writeM  output  1  memory write strobe for the current cycle.
REQ-008 addressM  output  15  memory address, equal to A[14:0].
REQ-009 pc  output  15  address of the next instruction to fetch.
REQ-010 halt  input  1  freeze request; port exists only when CPU_HALT_EN is defined.

Function
REQ-011 State SHALL be exactly three registers: A (16b), D (16b) and PC (15b); the block is single-cycle, with one instruction per clk.
REQ-012 When instruction[15]=0 (A-instruction), the block SHALL load A<=instruction on the edge; D is unchanged, writeM=0, and no jump is taken.
REQ-013 When instruction[15]=1 (C-instruction), the instantiated alu SHALL receive x=D, and y=inM if instruction[12]=1, else y=A.
REQ-014 The ALU controls zx,nx,zy,ny,f,no SHALL be instruction[11:6], MSB first; instruction[14:13] are ignored.
REQ-015 outM SHALL be the combinational ALU output; it is don't-care for A-instructions.
REQ-016 The dest bits SHALL be [5]=A, [4]=D, [3]=M. A<=outM and D<=outM on the edge when their bit is set.
REQ-017 writeM SHALL equal instruction[15]&instruction[3], combinationally.
REQ-018 The jump bits SHALL be [2]=JLT, [1]=JEQ, [0]=JGT. The jump is taken if (j2&ng)|(j1&zr)|(j0&~ng&~zr), using the ALU zr/ng flags.
REQ-019 PC update: if reset, PC<=0; else if the jump is taken, PC<=A[14:0]; else PC<=PC+1.
REQ-020 PC SHALL wrap from 0x7FFF to 0x0000 with no flag.
REQ-021 Simultaneous A write and jump: the jump target SHALL be the A value held before the edge.
REQ-022 Simultaneous A write and M write: addressM SHALL be the pre-edge A, because addressM is always the registered A.
REQ-023 Reading M while writing M: the ALU uses the current inM; the memory write lands on the edge.

Reset
REQ-024 While reset=1, the edge SHALL set A=0, D=0 and PC=0, overriding any load or jump.
REQ-025 While reset=1, writeM SHALL be forced to 0.
REQ-026 After reset: addressM=0 and pc=0. outM follows the instruction input.
REQ-027 Reset asserted mid-program SHALL take effect on the next edge, with no partial register update.
REQ-028 The first instruction executed after reset deasserts SHALL be ROM[0].

Configuration
REQ-029 CPU_HALT_EN defined: the halt port SHALL exist.
REQ-030 With CPU_HALT_EN, halt=1 and reset=0: A, D and PC SHALL hold, and writeM SHALL be forced to 0.
REQ-031 With CPU_HALT_EN, reset SHALL override halt.
REQ-032 CPU_HALT_EN undefined: the halt port SHALL be absent and behaviour is as if halt=0.

Verification
REQ-033 reset=1 one cycle, then instruction=0x0005 -> after the edge: addressM=5, pc=1, writeM=0.
REQ-034 Load A=7, then 0xEC10 (D=A), then 0xE7C8 (M=D+1) -> during the third cycle: outM=8, writeM=1, addressM=7; D=7.
REQ-035 instruction=0x0064, then 0xEA87 (0;JMP) -> pc=100 after the second edge.
REQ-036 D=0, then 0xE304 (D;JLT) -> no jump, pc increments. D=0xFFFF, then 0xE304 -> pc=A[14:0].
REQ-037 PC at 0x7FFF with a non-jump instruction -> pc=0x0000 next cycle. reset asserted during a jump instruction -> pc=0, writeM=0.
REQ-038 (CPU_HALT_EN) halt=1 for 3 cycles during 0xE7C8 -> pc, A and D unchanged, writeM=0. Execution resumes when halt=0.
